uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 155 +++++++++++++++
 tb/tb_uart_tx_arb.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that lets NUM_REQ requesters share one uart_tx, one frame in flight.
// Optional frame watchdog: define UART_ARB_TIMEOUT_EN to enable timeout_err/err_id.
module uart_tx_arb #(
  parameter int NUM_REQ        = 4,
  parameter int data_wd        = 8,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*data_wd-1:0] req_data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic                       tx_start,
  output logic [data_wd-1:0]         din,
  input  logic                       tx_done,
  output logic                       timeout_err,
  output logic [$clog2(NUM_REQ)-1:0] err_id,
  output logic [3:0]                 dbg_state
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [3:0] {
    IDLE      = 4'b0001,
    LAUNCH    = 4'b0010,
    WAIT_DONE = 4'b0100,
    HOLDOFF   = 4'b1000
  } state_t;

  state_t             state_q;
  logic [IDW-1:0]     ptr_q;
  logic [IDW-1:0]     win_q;
  logic [data_wd-1:0] din_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] done_q;
  logic               tx_start_q;
  logic               tx_done_q;
  logic               tx_done_rise;
  logic               timeout_hit;
  logic               sel_found_d;
  logic [IDW-1:0]     sel_idx_d;

  // Handshake: req[i] is a level held until gnt[i] pulses; on that pulse the byte
  // is already latched in din and the requester may drop or change req/req_data.
  assign tx_done_rise = tx_done & ~tx_done_q;

  // Search starts one past the last winner so every active requester is reached.
  always_comb begin
    logic [IDW-1:0] cand;
    sel_found_d = 1'b0;
    sel_idx_d   = '0;
    cand        = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (cand == IDW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      if (!sel_found_d && req[cand]) begin
        sel_found_d = 1'b1;
        sel_idx_d   = cand;
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]  cnt_q;
  logic           timeout_err_q;
  logic [IDW-1:0] err_id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == LAUNCH) begin
      cnt_q <= '0;
    end else if (state_q == WAIT_DONE) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == WAIT_DONE) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_err_q;
  assign err_id      = err_id_q;
`else
  logic unused_cfg;
  assign unused_cfg  = (TIMEOUT_CYCLES != 0);
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
  assign err_id      = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= IDW'(NUM_REQ - 1);
      win_q         <= '0;
      din_q         <= '0;
      gnt_q         <= '0;
      done_q        <= '0;
      tx_start_q    <= 1'b0;
      tx_done_q     <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      timeout_err_q <= 1'b0;
      err_id_q      <= '0;
`endif
    end else begin
      tx_done_q     <= tx_done;
      tx_start_q    <= 1'b0;
      gnt_q         <= '0;
      done_q        <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      timeout_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (sel_found_d) begin
            win_q   <= sel_idx_d;
            din_q   <= req_data[sel_idx_d*data_wd +: data_wd];
            gnt_q   <= ONE << sel_idx_d;
            state_q <= LAUNCH;
          end
        end
        LAUNCH: begin
          tx_start_q <= 1'b1;
          state_q    <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done_rise) begin
            done_q  <= ONE << win_q;
            ptr_q   <= win_q;
            state_q <= HOLDOFF;
          end else if (timeout_hit) begin
`ifdef UART_ARB_TIMEOUT_EN
            timeout_err_q <= 1'b1;
            err_id_q      <= win_q;
`endif
            ptr_q   <= win_q;
            state_q <= HOLDOFF;
          end
        end
        HOLDOFF: begin
          // Wait for uart_tx to drop tx_done so it is idle before the next tx_start.
          if (!tx_done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign tx_start  = tx_start_q;
  assign din       = din_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed scenarios plus a randomized run against a round-robin reference.
module tb_uart_tx_arb;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 100;
  localparam logic [N-1:0] ONE = N'(1);
  localparam logic [3:0] ST_IDLE = 4'b0001;
  localparam logic [3:0] ST_WAIT = 4'b0100;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0] gnt;
  logic [N-1:0] done;
  logic         tx_start;
  logic [W-1:0] din;
  logic         tx_done = 1'b0;
  logic         timeout_err;
  logic [1:0]   err_id;
  logic [3:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [W-1:0] exp_q[$];
  int           id_q[$];

  bit uart_en = 1'b1;
  int uart_lat_min = 3;
  int uart_lat_max = 3;
  int uart_hold = 1;
  bit u_busy = 1'b0;
  int u_cnt = 0;
  int u_hold = 0;
  int outstanding = 0;

  uart_tx_arb #(.NUM_REQ(N), .data_wd(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .gnt(gnt), .done(done), .tx_start(tx_start), .din(din),
    .tx_done(tx_done), .timeout_err(timeout_err), .err_id(err_id),
    .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // uart_tx stand-in: after tx_start, wait a random latency then hold tx_done high
  always @(negedge clk) begin
    if (!rst_n) begin
      u_busy  = 1'b0;
      tx_done = 1'b0;
    end else if (u_busy) begin
      if (u_cnt > 0) u_cnt--;
      else if (u_hold > 0) begin tx_done = 1'b1; u_hold--; end
      else begin tx_done = 1'b0; u_busy = 1'b0; end
    end else if (tx_start && uart_en) begin
      u_busy = 1'b1;
      u_cnt  = $urandom_range(uart_lat_max, uart_lat_min);
      u_hold = (uart_hold == 0) ? $urandom_range(2, 1) : uart_hold;
    end
  end

  // always-on monitor: exclusive pulses, one-hot gnt, one frame outstanding
  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding = 0;
    end else begin
      if (gnt != 0 || done != 0 || timeout_err) begin
        n_checks++;
        if (int'(gnt != 0) + int'(done != 0) + int'(timeout_err) > 1) begin
          n_fail++;
          $display("FAIL excl: gnt=%b done=%b timeout_err=%b, want at most one active", gnt, done, timeout_err);
        end
      end
      if (gnt != 0) begin
        n_checks++;
        if (!$onehot(gnt)) begin
          n_fail++;
          $display("FAIL gnt_onehot: gnt=%b, want one-hot", gnt);
        end
      end
      if (tx_start) begin
        n_checks++;
        if (outstanding != 0) begin
          n_fail++;
          $display("FAIL overlap: tx_start with %0d frame outstanding, want 0", outstanding);
        end
        outstanding = 1;
      end
      if (done != 0 || timeout_err) outstanding = 0;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    uart_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({gnt, done, tx_start, din, timeout_err, err_id} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: gnt=%b done=%b tx_start=%b din=%h to=%b id=%0d, want all 0",
               gnt, done, tx_start, din, timeout_err, err_id);
    end
    n_checks++;
    if (dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %b, want %b", dbg_state, ST_IDLE);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({gnt, done, tx_start} !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: gnt=%b done=%b tx_start=%b, want 0", gnt, done, tx_start);
    end
  endtask

  task automatic test_single();
    int n_done;
    bit din_ok;
    uart_lat_min = 3; uart_lat_max = 3; uart_hold = 1;
    rand_data();
    req_data[7:0] = 8'hA5;
    req = 4'b0001;
    @(negedge clk);
    n_checks++;
    if (gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt: got %b, want 0001", gnt); end
    req = '0;
    @(negedge clk);
    n_checks++;
    if (tx_start !== 1'b1 || din !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_launch: tx_start=%b din=%h, want 1 a5", tx_start, din);
    end
    n_done = 0;
    din_ok = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (din !== 8'hA5) din_ok = 1'b0;
      if (done != 0) begin
        n_done++;
        n_checks++;
        if (done !== 4'b0001) begin n_fail++; $display("FAIL single_done: got %b, want 0001", done); end
      end
    end
    n_checks++;
    if (n_done != 1) begin n_fail++; $display("FAIL single_done_count: got %0d, want 1", n_done); end
    n_checks++;
    if (!din_ok) begin n_fail++; $display("FAIL single_din_stable: din changed, want a5 held"); end
  endtask

  task automatic test_round_robin();
    int prev;
    bit hit;
    logic [N-1:0] exp_g;
    do_reset();
    uart_lat_min = 2; uart_lat_max = 6; uart_hold = 1;
    rand_data();
    req  = 4'b1111;
    prev = -1;
    for (int k = 0; k < 5; k++) begin
      hit = 1'b0;
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        if (done != 0 && prev >= 0) begin
          n_checks++;
          if (done !== (ONE << prev)) begin n_fail++; $display("FAIL rr_done: got %b, want %b", done, ONE << prev); end
        end
        if (gnt != 0) begin hit = 1'b1; break; end
      end
      exp_g = ONE << (k % N);
      n_checks++;
      if (!hit || gnt !== exp_g) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got %b, want %b", k, gnt, exp_g);
      end
      @(negedge clk);
      n_checks++;
      if (tx_start !== 1'b1 || din !== req_data[(k % N)*W +: W]) begin
        n_fail++;
        $display("FAIL rr_launch[%0d]: tx_start=%b din=%h, want 1 %h", k, tx_start, din, req_data[(k % N)*W +: W]);
      end
      prev = k % N;
    end
    req = '0;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_done_hold();
    int g1, g2, d1, nd;
    uart_lat_min = 2; uart_lat_max = 2; uart_hold = 2;
    rand_data();
    req = 4'b0011;
    g1 = -1; g2 = -1; d1 = -1; nd = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (done != 0) begin nd++; if (d1 < 0) d1 = cyc; end
      if (gnt != 0) begin
        req = req & ~gnt;
        if (g1 < 0) g1 = cyc;
        else begin g2 = cyc; break; end
      end
    end
    @(negedge clk);
    n_checks++;
    if (g2 < 0 || tx_start !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_second_frame: g2=%0d tx_start=%b, want second grant then tx_start", g2, tx_start);
    end
    n_checks++;
    if (nd != 1) begin n_fail++; $display("FAIL hold_done_count: got %0d, want 1", nd); end
    n_checks++;
    if (g2 - d1 != 3) begin n_fail++; $display("FAIL hold_regrant_gap: got %0d, want 3", g2 - d1); end
    req = '0;
    uart_hold = 1;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit hit;
    int stale;
    do_reset();
    uart_lat_min = 40; uart_lat_max = 40; uart_hold = 1;
    rand_data();
    req = 4'b0100;
    @(negedge clk);
    n_checks++;
    if (gnt !== 4'b0100) begin n_fail++; $display("FAIL mid_first_gnt: got %b, want 0100", gnt); end
    repeat (6) @(negedge clk);
    n_checks++;
    if (dbg_state !== ST_WAIT) begin n_fail++; $display("FAIL mid_in_wait: got %b, want %b", dbg_state, ST_WAIT); end
    rst_n = 1'b0;
    uart_lat_min = 3; uart_lat_max = 3;
    #1;
    n_checks++;
    if ({gnt, done, tx_start, din, timeout_err, err_id} !== '0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL mid_async_reset: gnt=%b done=%b tx_start=%b din=%h state=%b, want zeros/IDLE",
               gnt, done, tx_start, din, dbg_state);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hit = 1'b0; stale = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done != 0) stale++;
      if (gnt != 0) begin hit = 1'b1; break; end
    end
    n_checks++;
    if (!hit || gnt !== 4'b0100) begin n_fail++; $display("FAIL mid_regrant: got %b, want 0100", gnt); end
    req = '0;
    @(negedge clk);
    n_checks++;
    if (tx_start !== 1'b1 || din !== req_data[2*W +: W]) begin
      n_fail++;
      $display("FAIL mid_relaunch: tx_start=%b din=%h, want 1 %h", tx_start, din, req_data[2*W +: W]);
    end
    hit = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done != 0) begin hit = 1'b1; break; end
    end
    n_checks++;
    if (stale != 0) begin n_fail++; $display("FAIL mid_stale_done: got %0d pulses, want 0", stale); end
    n_checks++;
    if (!hit || done !== 4'b0100) begin n_fail++; $display("FAIL mid_done: got %b, want 0100", done); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_drop();
    int bad_g, nd;
    bit hit;
    uart_lat_min = 20; uart_lat_max = 20; uart_hold = 1;
    rand_data();
    req = 4'b0001;
    @(negedge clk);
    req = '0;
    repeat (5) @(negedge clk);
    req[3] = 1'b1;
    @(negedge clk);
    req[3] = 1'b0;
    bad_g = 0; nd = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (gnt != 0) bad_g++;
      if (done != 0) nd++;
    end
    n_checks++;
    if (bad_g != 0 || nd != 1) begin
      n_fail++;
      $display("FAIL drop_pulse: grants=%0d dones=%0d, want 0 grants 1 done", bad_g, nd);
    end
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    repeat (5) @(negedge clk);
    req[3] = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (gnt != 0) begin hit = 1'b1; break; end
    end
    n_checks++;
    if (!hit || gnt !== 4'b1000) begin n_fail++; $display("FAIL drop_held: got %b, want 1000", gnt); end
    req = '0;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_random();
    logic [W-1:0] lane_data[N];
    int           waitcnt[N];
    logic [N-1:0] req_seen;
    int           last, frames, exp;
    do_reset();
    uart_lat_min = 1; uart_lat_max = 8; uart_hold = 0;
    exp_q.delete(); id_q.delete();
    req_seen = '0; last = N - 1; frames = 0;
    for (int i = 0; i < N; i++) begin lane_data[i] = '0; waitcnt[i] = 0; end
    for (int c = 0; c < 4000 && frames < 40; c++) begin
      @(negedge clk);
      if (gnt != 0) begin
        exp = -1;
        for (int i = 1; i <= N; i++)
          if (exp < 0 && req_seen[(last + i) % N]) exp = (last + i) % N;
        n_checks++;
        if (exp < 0 || gnt !== (ONE << exp)) begin
          n_fail++;
          $display("FAIL rand_gnt: got %b, want index %0d (pending %b)", gnt, exp, req_seen);
        end
        if (exp >= 0) begin
          n_checks++;
          if (waitcnt[exp] > N - 1) begin
            n_fail++;
            $display("FAIL rand_fair: lane %0d waited %0d frames, want <= %0d", exp, waitcnt[exp], N - 1);
          end
          for (int i = 0; i < N; i++) if (req[i] && i != exp) waitcnt[i]++;
          exp_q.push_back(lane_data[exp]);
          id_q.push_back(exp);
          req[exp] = 1'b0;
          last = exp;
        end
      end
      if (tx_start) begin
        n_checks++;
        if (exp_q.size() == 0 || din !== exp_q[0]) begin
          n_fail++;
          $display("FAIL rand_din: got %h, want %h", din, (exp_q.size() != 0) ? exp_q[0] : '0);
        end
      end
      if (done != 0) begin
        n_checks++;
        if (id_q.size() == 0 || done !== (ONE << id_q[0])) begin
          n_fail++;
          $display("FAIL rand_done: got %b, want lane %0d", done, (id_q.size() != 0) ? id_q[0] : -1);
        end
        if (id_q.size() != 0) begin void'(id_q.pop_front()); void'(exp_q.pop_front()); end
        frames++;
      end
      for (int i = 0; i < N; i++) begin
        if (!req[i] && !gnt[i] && $urandom_range(7, 0) == 0) begin
          lane_data[i] = W'($urandom);
          req_data[i*W +: W] = lane_data[i];
          req[i] = 1'b1;
          waitcnt[i] = 0;
        end
      end
      req_seen = req;
    end
    n_checks++;
    if (frames < 40) begin n_fail++; $display("FAIL rand_progress: got %0d frames, want 40", frames); end
    req = '0;
    uart_hold = 1;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_timeout();
    int s, nd, to_cnt;
    bit hit;
    do_reset();
    uart_en = 1'b0;
    rand_data();
    req = 4'b0010;
    @(negedge clk);
    n_checks++;
    if (gnt !== 4'b0010) begin n_fail++; $display("FAIL to_gnt: got %b, want 0010", gnt); end
    req = '0;
    @(negedge clk);
    n_checks++;
    if (tx_start !== 1'b1) begin n_fail++; $display("FAIL to_launch: tx_start=%b, want 1", tx_start); end
    s = cyc;
    nd = 0; to_cnt = 0; hit = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (done != 0) nd++;
      if (timeout_err) begin hit = 1'b1; break; end
    end
    n_checks++;
    if (!hit || cyc - s != TO) begin n_fail++; $display("FAIL to_latency: got %0d cycles (hit=%b), want %0d", cyc - s, hit, TO); end
    n_checks++;
    if (err_id !== 2'd1) begin n_fail++; $display("FAIL to_err_id: got %0d, want 1", err_id); end
    n_checks++;
    if (nd != 0) begin n_fail++; $display("FAIL to_no_done: got %0d, want 0", nd); end
    @(negedge clk);
    n_checks++;
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_pulse_width: got %b, want 0", timeout_err); end
`else
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (done != 0) nd++;
      if (timeout_err) to_cnt++;
    end
    n_checks++;
    if (to_cnt != 0 || nd != 0 || err_id !== 2'd0) begin
      n_fail++;
      $display("FAIL to_disabled: timeouts=%0d dones=%0d err_id=%0d, want 0 0 0", to_cnt, nd, err_id);
    end
    n_checks++;
    if (dbg_state !== ST_WAIT) begin n_fail++; $display("FAIL to_stays_wait: got %b, want %b", dbg_state, ST_WAIT); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_done_hold();
    test_reset_mid();
    test_drop();
    test_random();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
